// File: rtl/digital_lock_pkg.sv
// Shared keypad constants, FSM state encodings and one-hot helper for the lock front end.
package digital_lock_pkg;

    localparam int KEY_WIDTH = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        PRESS_DB = ST_PRESS_DB,
        PRESSED  = ST_PRESSED,
        REL_DB   = ST_REL_DB
    } state_t;

    function automatic logic is_onehot4(input logic [KEY_WIDTH-1:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/key_synchroniser.sv
// Two-flop synchroniser for the keypad lines; 2-cycle latency, clears to released (0) on reset.
module key_synchroniser
    import digital_lock_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [KEY_WIDTH-1:0] din,
    output logic [KEY_WIDTH-1:0] dout
);

    logic [KEY_WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces 4 active-low buttons into one single-cycle one-hot pulse per press (D+3 cycles after a clean edge).
// KEYPAD_MULTIKEY_ERR_EN adds multi_err: multi-key presses in IDLE are flagged and must be fully released.
module keypad_debouncer
    import digital_lock_pkg::*;
#(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int DEBOUNCE_US = 10000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [KEY_WIDTH-1:0] key_raw,
    output logic [KEY_WIDTH-1:0] key,
`ifdef KEYPAD_MULTIKEY_ERR_EN
    output logic                 multi_err,
`endif
    output logic                 key_held
);

    localparam int DEBOUNCE_CYCLES = CLOCK_FREQ / 1000000 * DEBOUNCE_US;
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_D   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [KEY_WIDTH-1:0] key_s;
    logic [KEY_WIDTH-1:0] code, code_nxt;
    logic [KEY_WIDTH-1:0] key_nxt;
    logic [CNT_W-1:0]     count, count_nxt;
    state_t               state, state_nxt;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    logic                 err_nxt;
`endif

    key_synchroniser u_sync (
        .clock (clock),
        .reset (reset),
        .din   (~key_raw),
        .dout  (key_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            code  <= '0;
            key   <= '0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
            multi_err <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            code  <= code_nxt;
            key   <= key_nxt;
`ifdef KEYPAD_MULTIKEY_ERR_EN
            multi_err <= err_nxt;
`endif
        end
    end

    // Counter only advances below D, so it saturates without an explicit clamp.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        code_nxt  = code;
        key_nxt   = '0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
        err_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (is_onehot4(key_s)) begin
                    code_nxt  = key_s;
                    count_nxt = CNT_ONE;
                    state_nxt = PRESS_DB;
                end
`ifdef KEYPAD_MULTIKEY_ERR_EN
                else if (key_s != '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = PRESSED;
                end
`endif
            end
            PRESS_DB: begin
                if (key_s != code) begin
                    state_nxt = IDLE;
                end else if (count == CNT_D) begin
                    key_nxt   = code;
                    state_nxt = PRESSED;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            PRESSED: begin
                if (key_s == '0) begin
                    count_nxt = CNT_ONE;
                    state_nxt = REL_DB;
                end
            end
            REL_DB: begin
                if (key_s != '0) begin
                    state_nxt = PRESSED;
                end else if (count == CNT_D) begin
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign key_held = (state == PRESSED) || (state == REL_DB);

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboarded bench for keypad_debouncer with D=4: expected pulses are queued at stimulus time.
module tb_keypad_debouncer;

    logic       clock;
    logic       reset;
    logic [3:0] key_raw;
    logic [3:0] key;
    logic       key_held;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    logic       multi_err;
    int         merr_cnt = 0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    keypad_debouncer #(
        .CLOCK_FREQ  (1000000),
        .DEBOUNCE_US (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key_raw  (key_raw),
        .key      (key),
`ifdef KEYPAD_MULTIKEY_ERR_EN
        .multi_err(multi_err),
`endif
        .key_held (key_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Every nonzero key sample must match the oldest queued expectation, value and cycle.
    always @(negedge clock) begin
        exp_t e;
        if (key !== 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: key=%b at cycle %0d, required no pulse", key, cyc);
            end else begin
                e = sb.pop_front();
                if (key !== e.val || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL pulse: key=%b at cycle %0d, required %b at cycle %0d",
                             key, cyc, e.val, e.cyc);
                end
            end
        end
`ifdef KEYPAD_MULTIKEY_ERR_EN
        if (multi_err === 1'b1) merr_cnt++;
`endif
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Raw value driven just after edge k is first seen by the FSM at k+3; pulse visible after k+7.
    task automatic press_expect(input logic [3:0] raw, input logic [3:0] code);
        exp_t e;
        key_raw = raw;
        e.cyc = cyc + 7;
        e.val = code;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        key_raw = 4'hF;
        wait_cycles(3);
        checks++;
        if (key !== 4'b0000) begin
            fails++;
            $display("FAIL reset_key: got %b, required 0000", key);
        end
        checks++;
        if (key_held !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: got %b, required 0", key_held);
        end
        reset = 1'b0;
        wait_cycles(5);
        checks++;
        if (key_held !== 1'b0) begin
            fails++;
            $display("FAIL idle_held: got %b, required 0", key_held);
        end
    endtask

    task automatic test_clean_press;
        press_expect(4'b1101, 4'b0010);
        wait_cycles(20);
        checks++;
        if (key_held !== 1'b1) begin
            fails++;
            $display("FAIL clean_held: got %b, required 1", key_held);
        end
        key_raw = 4'hF;
        wait_cycles(6);
        checks++;
        if (key_held !== 1'b1) begin
            fails++;
            $display("FAIL release_held_late: got %b, required 1", key_held);
        end
        wait_cycles(1);
        checks++;
        if (key_held !== 1'b0) begin
            fails++;
            $display("FAIL release_done: got %b, required 0", key_held);
        end
        wait_cycles(4);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL clean_missing: %0d pulses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_bounce;
        key_raw = 4'b1110;
        wait_cycles(2);
        key_raw = 4'b1111;
        wait_cycles(1);
        press_expect(4'b1110, 4'b0001);
        wait_cycles(10);
        key_raw = 4'hF;
        wait_cycles(12);
        // Press visible for 4 FSM cycles is one short of D+1: no pulse.
        key_raw = 4'b1011;
        wait_cycles(4);
        key_raw = 4'hF;
        wait_cycles(12);
        // Exactly D+1 visible cycles is the shortest accepted press.
        press_expect(4'b1011, 4'b0100);
        wait_cycles(5);
        key_raw = 4'hF;
        wait_cycles(12);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL bounce_missing: %0d pulses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_hold;
        press_expect(4'b0111, 4'b1000);
        wait_cycles(100);
        checks++;
        if (key_held !== 1'b1) begin
            fails++;
            $display("FAIL hold_held: got %b, required 1", key_held);
        end
        key_raw = 4'hF;
        wait_cycles(12);
        checks++;
        if (key_held !== 1'b0 || sb.size() != 0) begin
            fails++;
            $display("FAIL hold_end: held=%b outstanding=%0d, required held=0 outstanding=0",
                     key_held, sb.size());
        end
    endtask

    task automatic test_multikey;
`ifdef KEYPAD_MULTIKEY_ERR_EN
        merr_cnt = 0;
`endif
        key_raw = 4'b1100;
        wait_cycles(20);
`ifdef KEYPAD_MULTIKEY_ERR_EN
        checks++;
        if (key_held !== 1'b1 || merr_cnt != 1) begin
            fails++;
            $display("FAIL multi_err: held=%b err_pulses=%0d, required held=1 err_pulses=1",
                     key_held, merr_cnt);
        end
`else
        checks++;
        if (key_held !== 1'b0) begin
            fails++;
            $display("FAIL multi_held: got %b, required 0", key_held);
        end
`endif
        key_raw = 4'hF;
        wait_cycles(12);
        checks++;
        if (key_held !== 1'b0) begin
            fails++;
            $display("FAIL multi_release: got %b, required 0", key_held);
        end
    endtask

    task automatic test_back_to_back;
        press_expect(4'b1110, 4'b0001);
        wait_cycles(10);
        key_raw = 4'b0110;
        wait_cycles(10);
        checks++;
        if (key_held !== 1'b1) begin
            fails++;
            $display("FAIL extra_key_held: got %b, required 1", key_held);
        end
        key_raw = 4'b1110;
        wait_cycles(5);
        key_raw = 4'hF;
        wait_cycles(7);
        press_expect(4'b1101, 4'b0010);
        wait_cycles(12);
        key_raw = 4'hF;
        wait_cycles(12);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_missing: %0d pulses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_press;
        key_raw = 4'b1011;
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(2);
        checks++;
        if (key_held !== 1'b0 || key !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_state: held=%b key=%b, required held=0 key=0000", key_held, key);
        end
        reset = 1'b0;
        press_expect(4'b1011, 4'b0100);
        wait_cycles(12);
        checks++;
        if (key_held !== 1'b1) begin
            fails++;
            $display("FAIL midreset_held: got %b, required 1", key_held);
        end
        key_raw = 4'hF;
        wait_cycles(12);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL midreset_missing: %0d pulses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        reset   = 1'b1;
        key_raw = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold();
        test_multikey();
        test_back_to_back();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
